// File: rtl/sym_vn_lut_loader.sv
// rtl/sym_vn_lut_loader.sv - pairs streamed IB-LUT entries into even/odd bank page writes
// One frame is PAGE_NUM pages of two entries each; each completed pair is written to both banks at once.
module sym_vn_lut_loader #(
   parameter  int LUT_PORT_SIZE   = 3,
   parameter  int ENTRY_ADDR      = 5,
   parameter  int MULTI_FRAME_NUM = 2,
   localparam int PAGE_W          = ENTRY_ADDR - $clog2(MULTI_FRAME_NUM),
   localparam int PAGE_NUM        = 2**PAGE_W
) (
   input  logic                     write_clk,
   input  logic                     rst,
   input  logic                     load_start,
   input  logic                     load_offset,
   input  logic [LUT_PORT_SIZE-1:0] entry_in,
   input  logic                     entry_valid,
   output logic                     entry_ready,
   output logic [LUT_PORT_SIZE-1:0] lut_in_bank0,
   output logic [LUT_PORT_SIZE-1:0] lut_in_bank1,
   output logic [PAGE_W-1:0]        page_write_addr,
   output logic                     write_addr_offset,
   output logic                     we,
   output logic                     load_busy,
   output logic                     load_done
);

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      COLLECT_EVEN = 2'd1,
      COLLECT_ODD  = 2'd2
   } state_t;

   state_t                   state_q;
   logic [PAGE_W-1:0]        page_q;
   logic [PAGE_W-1:0]        page_d;
   logic                     offset_q;
   logic [LUT_PORT_SIZE-1:0] even_q;
   logic [LUT_PORT_SIZE-1:0] bank0_q;
   logic [LUT_PORT_SIZE-1:0] bank1_q;
   logic [PAGE_W-1:0]        addr_q;
   logic                     woff_q;
   logic                     we_q;
   logic                     done_q;
   logic                     last_page;

   assign page_d    = page_q + 1'b1;
   assign last_page = (page_q == PAGE_W'(PAGE_NUM - 1));

   always_ff @(posedge write_clk) begin
      if (rst) begin
         state_q  <= IDLE;
         page_q   <= '0;
         offset_q <= 1'b0;
         even_q   <= '0;
         bank0_q  <= '0;
         bank1_q  <= '0;
         addr_q   <= '0;
         woff_q   <= 1'b0;
         we_q     <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         we_q   <= 1'b0;
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (load_start) begin
                  offset_q <= load_offset;
                  page_q   <= '0;
                  state_q  <= COLLECT_EVEN;
               end
            end
            COLLECT_EVEN: begin
               if (entry_valid) begin
                  even_q  <= entry_in;
                  state_q <= COLLECT_ODD;
               end
            end
            COLLECT_ODD: begin
               // Odd entry completes the page; write data is held until the next write.
               if (entry_valid) begin
                  we_q    <= 1'b1;
                  bank0_q <= even_q;
                  bank1_q <= entry_in;
                  addr_q  <= page_q;
                  woff_q  <= offset_q;
                  page_q  <= page_d;
                  if (last_page) begin
                     done_q  <= 1'b1;
                     state_q <= IDLE;
                  end else begin
                     state_q <= COLLECT_EVEN;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign entry_ready       = (state_q != IDLE);
   assign load_busy         = (state_q != IDLE);
   assign lut_in_bank0      = bank0_q;
   assign lut_in_bank1      = bank1_q;
   assign page_write_addr   = addr_q;
   assign write_addr_offset = woff_q;
   assign we                = we_q;
   assign load_done         = done_q;

endmodule

// File: tb/tb_sym_vn_lut_loader.sv
// tb/tb_sym_vn_lut_loader.sv - randomized and directed bench against an entry-count reference model
module tb_sym_vn_lut_loader;

   localparam int LW = 3;
   localparam int PW = 4;
   localparam int NE = 32;

   logic          write_clk = 1'b0;
   logic          rst = 1'b1;
   logic          load_start = 1'b0;
   logic          load_offset = 1'b0;
   logic [LW-1:0] entry_in = '0;
   logic          entry_valid = 1'b0;
   logic          entry_ready;
   logic [LW-1:0] lut_in_bank0;
   logic [LW-1:0] lut_in_bank1;
   logic [PW-1:0] page_write_addr;
   logic          write_addr_offset;
   logic          we;
   logic          load_busy;
   logic          load_done;

   sym_vn_lut_loader dut (
      .write_clk         (write_clk),
      .rst               (rst),
      .load_start        (load_start),
      .load_offset       (load_offset),
      .entry_in          (entry_in),
      .entry_valid       (entry_valid),
      .entry_ready       (entry_ready),
      .lut_in_bank0      (lut_in_bank0),
      .lut_in_bank1      (lut_in_bank1),
      .page_write_addr   (page_write_addr),
      .write_addr_offset (write_addr_offset),
      .we                (we),
      .load_busy         (load_busy),
      .load_done         (load_done)
   );

   always #5 write_clk = ~write_clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: a frame is NE accepted entries; entry k pairs with k^1 into page k/2.
   bit            m_busy = 0;
   int            m_cnt  = 0;
   bit            m_off  = 0;
   logic [LW-1:0] m_held = '0;
   logic [LW-1:0] m_b0   = '0;
   logic [LW-1:0] m_b1   = '0;
   logic [PW-1:0] m_addr = '0;
   bit            m_woff = 0;
   bit            m_we   = 0;
   bit            m_done = 0;
   int            we_seen   = 0;
   int            done_seen = 0;
   int            off1_seen = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic cyc(input bit r, input bit ls, input bit lo, input bit ev, input logic [LW-1:0] d);
      @(negedge write_clk);
      check("entry_ready", {31'd0, entry_ready}, {31'd0, m_busy});
      check("load_busy", {31'd0, load_busy}, {31'd0, m_busy});
      check("we", {31'd0, we}, {31'd0, m_we});
      check("load_done", {31'd0, load_done}, {31'd0, m_done});
      check("bank0", {29'd0, lut_in_bank0}, {29'd0, m_b0});
      check("bank1", {29'd0, lut_in_bank1}, {29'd0, m_b1});
      check("page_addr", {28'd0, page_write_addr}, {28'd0, m_addr});
      check("wr_offset", {31'd0, write_addr_offset}, {31'd0, m_woff});
      if (we) begin
         we_seen++;
         if (write_addr_offset) off1_seen++;
      end
      if (load_done) done_seen++;
      rst         = r;
      load_start  = ls;
      load_offset = lo;
      entry_valid = ev;
      entry_in    = d;
      @(posedge write_clk);
      m_we   = 0;
      m_done = 0;
      if (r) begin
         m_busy = 0; m_cnt = 0; m_off = 0; m_held = '0;
         m_b0 = '0; m_b1 = '0; m_addr = '0; m_woff = 0;
      end else if (!m_busy) begin
         if (ls) begin
            m_busy = 1; m_cnt = 0; m_off = lo;
         end
      end else if (ev) begin
         if (m_cnt % 2 == 0) begin
            m_held = d;
         end else begin
            m_we   = 1;
            m_b0   = m_held;
            m_b1   = d;
            m_addr = PW'(m_cnt / 2);
            m_woff = m_off;
            if (m_cnt == NE - 1) begin
               m_done = 1;
               m_busy = 0;
            end
         end
         m_cnt = (m_cnt + 1) % NE;
      end
   endtask

   // Streams n entries of value idx%8; mode 1 toggles valid; ign_page>=0 pulses load_start(offset 0) there.
   task automatic feed(input bit off, input int n, input int mode, input int ign_page);
      int idx = 0;
      int t   = 0;
      cyc(0, 1, off, 0, '0);
      while (idx < n && t < 400) begin
         bit ev = (mode == 1) ? (t % 2 == 0) : 1'b1;
         bit ls = (ign_page >= 0 && idx == 2 * ign_page && ev);
         cyc(0, ls, 0, ev, LW'(idx % 8));
         if (ev) idx++;
         t++;
      end
      check("feed_timeout", {31'd0, (t >= 400)}, 32'd0);
   endtask

   initial begin
      int w0, d0, o0;
      repeat (2) @(posedge write_clk);

      // Full frame, continuous stream, offset 1
      w0 = we_seen; d0 = done_seen; o0 = off1_seen;
      feed(1, NE, 0, -1);
      repeat (3) cyc(0, 0, 0, 0, '0);
      check("frame_we_count", we_seen - w0, 16);
      check("frame_done_count", done_seen - d0, 1);
      check("frame_off1_count", off1_seen - o0, 16);

      // Valid toggling every cycle
      w0 = we_seen; d0 = done_seen;
      feed(0, NE, 1, -1);
      repeat (3) cyc(0, 0, 0, 0, '0);
      check("toggle_we_count", we_seen - w0, 16);
      check("toggle_done_count", done_seen - d0, 1);

      // Ignored load_start mid-frame
      w0 = we_seen; o0 = off1_seen;
      feed(1, NE, 0, 5);
      repeat (3) cyc(0, 0, 0, 0, '0);
      check("ignore_we_count", we_seen - w0, 16);
      check("ignore_off1_count", off1_seen - o0, 16);

      // Reset with page 6 half collected
      w0 = we_seen;
      feed(1, 13, 0, -1);
      cyc(1, 1, 1, 1, 3'd5);
      repeat (5) cyc(0, 0, 0, 1, 3'd6);
      check("rst_mid_we_count", we_seen - w0, 6);
      check("rst_mid_ready", {31'd0, entry_ready}, 32'd0);

      // Valid in IDLE with no load_start
      w0 = we_seen;
      repeat (20) cyc(0, 0, 0, 1, LW'($urandom));
      check("idle_we_count", we_seen - w0, 0);

      // Back-to-back frames
      w0 = we_seen; d0 = done_seen;
      feed(1, NE, 0, -1);
      cyc(0, 0, 0, 0, '0);
      feed(0, NE, 0, -1);
      repeat (3) cyc(0, 0, 0, 0, '0);
      check("b2b_we_count", we_seen - w0, 32);
      check("b2b_done_count", done_seen - d0, 2);

      // Random traffic, including start+valid in the same IDLE cycle and occasional reset
      for (int i = 0; i < 1500; i++) begin
         cyc(($urandom % 100) == 0, ($urandom % 8) == 0, $urandom % 2,
             ($urandom % 4) != 0, LW'($urandom));
      end
      repeat (3) cyc(0, 0, 0, 0, '0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/sym_vn_lut_loader.md
SYM_VN_LUT_LOADER -- requirements
Module: sym_vn_lut_loader

Interface
REQ-001 SHALL have parameter LUT_PORT_SIZE, default 3, width of one IB-LUT entry.
REQ-002 SHALL have parameter ENTRY_ADDR, default 5, LUT entry address width incl. frame offset.
REQ-003 SHALL have parameter MULTI_FRAME_NUM, default 2, number of LUT frames; PAGE_W = ENTRY_ADDR-$clog2(MULTI_FRAME_NUM), PAGE_NUM = 2**PAGE_W.
REQ-004 write_clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 load_start  input  1  one-cycle request to begin loading one full LUT frame.
REQ-007 load_offset  input  1  target frame (write_addr_offset value), sampled with load_start.
REQ-008 entry_in  input  LUT_PORT_SIZE  LUT entry stream, natural entry order.
REQ-009 entry_valid  input  1  entry_in valid.
REQ-010 entry_ready  output  1  loader accepts entry_in this cycle.
REQ-011 lut_in_bank0  output  LUT_PORT_SIZE  even-entry write data to the symmetric VN LUT.
REQ-012 lut_in_bank1  output  LUT_PORT_SIZE  odd-entry write data to the symmetric VN LUT.
REQ-013 page_write_addr  output  PAGE_W  page address of current write.
REQ-014 write_addr_offset  output  1  frame offset of current write.
REQ-015 we  output  1  one-cycle write strobe, both banks written together.
REQ-016 load_busy  output  1  frame load in progress.
REQ-017 load_done  output  1  one-cycle pulse on final page write of a frame.

Function
REQ-018 SHALL implement states IDLE, COLLECT_EVEN, COLLECT_ODD.
REQ-019 In IDLE, load_start=1 SHALL latch load_offset, clear page counter to 0, go COLLECT_EVEN next cycle.
REQ-020 entry_ready SHALL be 1 exactly in COLLECT_EVEN and COLLECT_ODD; an entry transfers when entry_valid & entry_ready.
REQ-021 Transfer in COLLECT_EVEN SHALL store entry into bank0 holding register and go COLLECT_ODD; no transfer holds state.
REQ-022 Transfer in COLLECT_ODD on cycle N SHALL drive we=1 on cycle N+1 with lut_in_bank0=held even entry, lut_in_bank1=odd entry, page_write_addr=page counter, write_addr_offset=latched offset.
REQ-023 After each page write the page counter SHALL increment by 1 (PAGE_W bits).
REQ-024 Transfer in COLLECT_ODD with page counter < PAGE_NUM-1 SHALL go COLLECT_EVEN; with page counter = PAGE_NUM-1 SHALL go IDLE.
REQ-025 load_done SHALL pulse 1 on the same cycle as the we of page PAGE_NUM-1; page counter wraps to 0.
REQ-026 Throughput SHALL be one entry per cycle; entry_ready stays 1 during we cycles except after the final entry.
REQ-027 we SHALL be 0 on every cycle not following an odd-entry transfer; lut_in_bank*/page_write_addr/write_addr_offset SHALL hold last written values when we=0.
REQ-028 load_busy SHALL be 1 in COLLECT_EVEN/COLLECT_ODD and 0 in IDLE.
REQ-029 load_start while load_busy=1 SHALL be ignored (no restart, offset unchanged).
REQ-030 Entries presented while in IDLE SHALL be neither accepted nor written; load_start and entry_valid in the same IDLE cycle SHALL not accept that entry.
REQ-031 entry_valid dropping mid-frame SHALL stall without losing the held even entry or page count.

Reset
REQ-032 rst=1 SHALL force IDLE, page counter 0, latched offset 0, we=0, load_done=0, load_busy=0, entry_ready=0, lut_in_bank0=0, lut_in_bank1=0, page_write_addr=0, write_addr_offset=0 on the next edge.
REQ-033 rst during a load SHALL discard any partial page (no we) and require a new load_start.
REQ-034 rst SHALL take priority over load_start and entry transfers in the same cycle.

Verification
REQ-035 Reset, load_start with load_offset=1, stream 0..7 repeating continuously for 2*PAGE_NUM entries -> 16 we pulses on alternate cycles, page 0..15, bank0=even, bank1=odd, offset=1, load_done with page 15.
REQ-036 Frame load with entry_valid toggled 1/0 every cycle -> identical writes to REQ-035, we spaced 4 cycles, no lost entry.
REQ-037 load_start pulse at page 5 of a load with load_offset=0 -> ignored, remaining writes keep offset 1, pages continue 6..15.
REQ-038 rst asserted after entry 13 (odd page 6 pending holding even entry) -> no we for page 6, all outputs 0, entry_ready 0 until next load_start.
REQ-039 entry_valid=1 in IDLE with no load_start -> entry_ready=0, we=0 for 20 cycles.
REQ-040 Back-to-back frames: load_start offset 0 the cycle after load_done -> second frame writes pages 0..15 offset 0, first frame unaffected.
